// File: rtl/hc4e_pkg.sv
// hc4e_pkg: arbiter state encoding and instruction-class constants for the HC4e core
package hc4e_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    FORCE = 2'd2
  } arb_state_t;
  localparam logic [2:0] OP_LD_RAM = 3'b100;
  localparam logic [2:0] OP_LD_IMM = 3'b101;
  localparam logic [2:0] OP_JP     = 3'b111;
  // ALU ops and stores share a leading 0 in instruction[7]
  function automatic logic is_ram_wr(input logic [2:0] op);
    return !op[2];
  endfunction
  function automatic logic is_ram_rd(input logic [2:0] op);
    return op == OP_LD_RAM;
  endfunction
endpackage

// File: rtl/hc4e_ram_arbiter_if.sv
// hc4e_ram_arbiter_if: CPU strobe/data bus and host debug port of the RAM arbiter
//   cpu_*  : CPU read/write strobes, address, write data, comb read data, stall
//   host_* : valid/ready request handshake, registered read data with rvalid pulse
interface hc4e_ram_arbiter_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 4
);
  logic              cpu_rd;
  logic              cpu_wr;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_stall;
  logic              host_valid;
  logic              host_we;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_wdata;
  logic              host_ready;
  logic [DATA_W-1:0] host_rdata;
  logic              host_rvalid;
  modport slave (
    input  cpu_rd, cpu_wr, cpu_addr, cpu_wdata, host_valid, host_we, host_addr, host_wdata,
    output cpu_rdata, cpu_stall, host_ready, host_rdata, host_rvalid
  );
  modport master (
    output cpu_rd, cpu_wr, cpu_addr, cpu_wdata, host_valid, host_we, host_addr, host_wdata,
    input  cpu_rdata, cpu_stall, host_ready, host_rdata, host_rvalid
  );
endinterface

// File: rtl/hc4e_ram16x4.sv
// hc4e_ram16x4: cleared-on-reset RAM array, one write port, comb CPU read, registered host read
//   i_we/i_waddr/i_wdata : single (pre-muxed) write port
//   i_raddr/o_rdata      : combinational read port
//   i_hre/i_haddr        : host read strobe; o_hrdata holds the word, o_hrvalid pulses next cycle
module hc4e_ram16x4 #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 4
) (
  input  logic              clk,
  input  logic              nReset,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata,
  input  logic              i_hre,
  input  logic [ADDR_W-1:0] i_haddr,
  output logic [DATA_W-1:0] o_hrdata,
  output logic              o_hrvalid
);
  localparam int DEPTH = 2 ** ADDR_W;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_hrdata;
  logic              r_hrvalid;
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_hrdata  <= '0;
      r_hrvalid <= 1'b0;
    end else begin
      if (i_we) r_mem[i_waddr] <= i_wdata;
      if (i_hre) r_hrdata <= r_mem[i_haddr];
      r_hrvalid <= i_hre;
    end
  end
  assign o_rdata   = r_mem[i_raddr];
  assign o_hrdata  = r_hrdata;
  assign o_hrvalid = r_hrvalid;
endmodule

// File: rtl/hc4e_ram_arbiter.sv
// hc4e_ram_arbiter: shares the HC4e data RAM between the CPU (priority) and the host port
//   clk, nReset : clock, async active-low reset
//   bus         : CPU strobes/data and host valid/ready request port (slave side)
module hc4e_ram_arbiter
  import hc4e_pkg::*;
#(
  parameter int ADDR_W   = 4,
  parameter int DATA_W   = 4,
  parameter int MAX_WAIT = 4
) (
  input logic                clk,
  input logic                nReset,
  hc4e_ram_arbiter_if.slave  bus
);
  arb_state_t        r_state;
  logic [3:0]        r_wait_cnt;
  logic              r_stall;
  logic              w_grant;
  logic              w_host_we;
  logic              w_cpu_we;
  logic [3:0]        w_cnt_nxt;
  // host_ready is gated by nReset so nothing is granted while reset is held
  assign w_grant   = nReset && bus.host_valid && (r_state == FORCE || !(bus.cpu_rd || bus.cpu_wr));
  assign w_host_we = w_grant && bus.host_we;
  // a CPU write in the stall slot is dropped; the core replays it next cycle
  assign w_cpu_we  = bus.cpu_wr && !r_stall;
  assign w_cnt_nxt = r_wait_cnt + 4'd1;
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      r_state    <= IDLE;
      r_wait_cnt <= '0;
      r_stall    <= 1'b0;
    end else if (r_state == FORCE || w_grant || !bus.host_valid) begin
      r_state    <= IDLE;
      r_wait_cnt <= '0;
      r_stall    <= 1'b0;
    end else if (w_cnt_nxt == 4'(MAX_WAIT)) begin
      r_state    <= FORCE;
      r_wait_cnt <= '0;
      r_stall    <= 1'b1;
    end else begin
      r_state    <= WAIT;
      r_wait_cnt <= w_cnt_nxt;
      r_stall    <= 1'b0;
    end
  end
  hc4e_ram16x4 #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_ram (
    .clk       (clk),
    .nReset    (nReset),
    .i_we      (w_host_we || w_cpu_we),
    .i_waddr   (w_host_we ? bus.host_addr : bus.cpu_addr),
    .i_wdata   (w_host_we ? bus.host_wdata : bus.cpu_wdata),
    .i_raddr   (bus.cpu_addr),
    .o_rdata   (bus.cpu_rdata),
    .i_hre     (w_grant && !bus.host_we),
    .i_haddr   (bus.host_addr),
    .o_hrdata  (bus.host_rdata),
    .o_hrvalid (bus.host_rvalid)
  );
  assign bus.host_ready = w_grant;
  assign bus.cpu_stall  = r_stall;
endmodule

// File: doc/hc4e_ram_arbiter.md
Name: hc4e_ram_arbiter

Overview:
Owns the 16x4 data RAM of the HC4e core and shares it between the CPU and a host/debug port (program loader, monitor).
- CPU has fixed priority. The host is served in cycles where the CPU makes no RAM access.
- A starvation counter forces one host slot by stalling the CPU for exactly one cycle.
- Sits between the core's RAM strobes/data bus glue and the board-level debug interface.

Parameters:
ADDR_W, 4, RAM address width; depth = 2**ADDR_W.
DATA_W, 4, RAM word width.
MAX_WAIT, 4, consecutive denied host cycles before a forced slot; legal range 1..15.

Ports:
clk  input  1  clock; all state updates on rising edge.
nReset  input  1  asynchronous, active-low reset.
cpu_rd  input  1  CPU read this cycle (decoded LD from RAM, instruction[7:5]==100).
cpu_wr  input  1  CPU write this cycle (decoded instruction[7]==0).
cpu_addr  input  ADDR_W  CPU RAM address (instruction[3:0]).
cpu_wdata  input  DATA_W  CPU write data (ALU result).
cpu_rdata  output  DATA_W  combinational mem[cpu_addr].
cpu_stall  output  1  registered; core must hold PC and all state this cycle.
host_valid  input  1  host request pending.
host_we  input  1  1=write, 0=read.
host_addr  input  ADDR_W  host address.
host_wdata  input  DATA_W  host write data.
host_ready  output  1  grant; the request completes in the cycle where host_valid&&host_ready.
host_rdata  output  DATA_W  registered read data.
host_rvalid  output  1  one-cycle pulse, the cycle after a granted read.

Behaviour:
- Reset (async, nReset low):
  - state=IDLE, wait_cnt=0, cpu_stall=0, host_rvalid=0, host_rdata=0.
  - All RAM words are cleared to 0.
  - host_ready=0 while reset is asserted.
  - A pending host request is abandoned; the host must re-present it.
- FSM states:
  - IDLE: no host wait in progress.
  - WAIT: host denied at least once.
  - FORCE: stall slot.
  - cpu_stall = (state==FORCE).
- Grant: host_ready = host_valid && (state==FORCE || (!cpu_rd && !cpu_wr)).
- CPU access, when not stalled:
  - Write commits mem[cpu_addr]<=cpu_wdata on the clock edge.
  - cpu_rdata always reflects the array combinationally; zero latency.
- CPU access while stalled: any cpu_wr in the FORCE cycle is dropped. The core re-executes it next cycle.
- Host write when granted: mem[host_addr]<=host_wdata at the edge.
- Host read when granted: host_rdata<=mem[host_addr] at the edge and host_rvalid=1 for the next cycle. host_rdata holds its value until the next granted read.
- Transitions:
  - IDLE/WAIT with host_valid && !host_ready: wait_cnt<=wait_cnt+1. If wait_cnt+1==MAX_WAIT, go to FORCE; otherwise go to WAIT.
  - Any granted cycle: go to IDLE, wait_cnt<=0.
  - host_valid low in IDLE/WAIT: go to IDLE, wait_cnt<=0.
  - FORCE lasts exactly one cycle, then IDLE. If host_valid dropped (protocol violation), still return to IDLE; no access occurs.
- Host protocol: host_valid/we/addr/wdata are held stable until granted. Back-to-back host requests are allowed; the next request is evaluated in the cycle after a grant.
- Simultaneous cpu_rd && cpu_wr is illegal; it is treated as a write.
- Same-address ordering:
  - Host write at cycle N is visible on cpu_rdata in cycle N+1.
  - CPU write at N is visible to a host read granted at N+1 or later.
- wait_cnt width is 4 bits; it never exceeds MAX_WAIT-1.

Decomposition:
- Shared package hc4e_pkg holds:
  - Arbiter state encoding (IDLE=2'd0, WAIT=2'd1, FORCE=2'd2).
  - Instruction class constants (ALU/store 3'b0??, LD RAM 3'b100, LD imm 3'b101, JP 3'b111) used by the core glue to drive cpu_rd/cpu_wr.
- Sub-module hc4e_ram16x4: async-reset 16xDATA_W array with one write port (muxed by the arbiter), combinational CPU read port and registered host read port.

Test Plan:
- Idle CPU, host write addr 3 data 0xA:
  - Required: host_ready=1 in the same cycle, mem[3]=0xA after the edge.
  - Next cycle: cpu_addr=3, cpu_rd=1 gives cpu_rdata=0xA.
- CPU writes 0x5 to addr 7 while host_valid read addr 7 is pending:
  - Required: host denied in that cycle.
  - Next idle cycle: host granted; host_rvalid pulses one cycle later with host_rdata=0x5.
- CPU asserts cpu_wr every cycle; host read pending with MAX_WAIT=4:
  - Required: host_ready=0 for cycles 0-3.
  - Cycle 4: cpu_stall=1 and host_ready=1.
  - Cycle 5: cpu_stall=0, state IDLE, host_rvalid=1.
- Forced slot with cpu_wr addr 2 data 0xF in the FORCE cycle:
  - Required: mem[2] unchanged in that cycle.
  - Core retries next cycle and mem[2]=0xF after that cycle's edge.
- host_valid deasserted after 2 denied cycles, then reasserted:
  - Required: wait_cnt returns to 0.
  - A forced slot needs 4 fresh denied cycles.
- nReset pulsed low mid-WAIT (wait_cnt=3) between edges:
  - Required: cpu_stall=0, host_ready=0 and host_rvalid=0 immediately.
  - All RAM words read 0 after release.
